// File: rtl/text_renderer_if.sv
// Pixel write bus between the text renderer (master) and a pixel sink (slave).
interface text_renderer_if;
    logic [7:0] plot_x;
    logic [7:0] plot_y;
    logic [5:0] plot_colour;
    logic       plot;
    logic       plot_ready;

    modport master (output plot_x, plot_y, plot_colour, plot, input plot_ready);
    modport slave  (input plot_x, plot_y, plot_colour, plot, output plot_ready);
endinterface

// File: rtl/text_renderer.sv
// Draws a string of bitmap glyphs as a stream of pixel writes, fetching one
// glyph row per LOAD cycle from an external combinational glyph ROM.
module text_renderer #(
    parameter int NUM_CHARS   = 4,
    parameter int CHAR_W      = 8,
    parameter int CHAR_H      = 10,
    parameter int SPACING     = 1,
    parameter bit TRANSPARENT = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [7:0]             x,
    input  logic [7:0]             y,
    input  logic [6*NUM_CHARS-1:0] chars,
    input  logic [5:0]             fg_colour,
    input  logic [5:0]             bg_colour,
    output logic [5:0]             glyph_code,
    output logic [3:0]             glyph_row,
    input  logic [7:0]             glyph_bits,
    text_renderer_if.master        pix,
    output logic                   busy,
    output logic                   done
);

    localparam int                SLOT_W    = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
    localparam logic [7:0]        PITCH     = 8'(CHAR_W + SPACING);
    localparam logic [2:0]        LAST_COL  = 3'(CHAR_W - 1);
    localparam logic [3:0]        LAST_ROW  = 4'(CHAR_H - 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_CHARS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        DRAW   = 2'd2,
        FINISH = 2'd3
    } state_t;

    typedef struct packed {
        logic       plot;
        logic [7:0] px;
        logic [7:0] py;
        logic [5:0] colour;
    } pix_t;

    state_t                 state_q, state_d;
    logic [SLOT_W-1:0]      slot_q, slot_d;
    logic [3:0]             row_q, row_d;
    logic [2:0]             col_q, col_d;
    logic [7:0]             base_x_q, base_x_d;
    logic [7:0]             y_q, y_d;
    logic [6*NUM_CHARS-1:0] chars_q, chars_d;
    logic [5:0]             fg_q, fg_d;
    logic [5:0]             bg_q, bg_d;
    logic [7:0]             bits_q, bits_d;
    pix_t                   pix_q, pix_d;
    logic [5:0]             glyph_code_q, glyph_code_d;
    logic [3:0]             glyph_row_q, glyph_row_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    // Bit 7 of a glyph row is its leftmost column.
    function automatic pix_t pixel(input logic [7:0] bx, input logic [7:0] py,
                                   input logic [7:0] b, input logic [2:0] c,
                                   input logic [5:0] fg, input logic [5:0] bg);
        pix_t p;
        logic set;
        set      = b[3'd7 - c];
        p.plot   = set | !TRANSPARENT;
        p.px     = bx + {5'd0, c};
        p.py     = py;
        p.colour = set ? fg : bg;
        return p;
    endfunction

    // Next-state, counter and pixel computation; base_x_q tracks column 0 of the current slot.
    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        row_d        = row_q;
        col_d        = col_q;
        base_x_d     = base_x_q;
        y_d          = y_q;
        chars_d      = chars_q;
        fg_d         = fg_q;
        bg_d         = bg_q;
        bits_d       = bits_q;
        pix_d        = pix_q;
        glyph_code_d = glyph_code_q;
        glyph_row_d  = glyph_row_q;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = LOAD;
                    slot_d       = '0;
                    row_d        = 4'd0;
                    col_d        = 3'd0;
                    base_x_d     = x;
                    y_d          = y;
                    chars_d      = chars;
                    fg_d         = fg_colour;
                    bg_d         = bg_colour;
                    glyph_code_d = chars[5:0];
                    glyph_row_d  = 4'd0;
                    busy_d       = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                state_d = DRAW;
                bits_d  = glyph_bits;
                col_d   = 3'd0;
                pix_d   = pixel(base_x_q, y_q + {4'd0, row_q}, glyph_bits, 3'd0, fg_q, bg_q);
                busy_d  = 1'b1;
            end
            DRAW: begin
                busy_d = 1'b1;
                if (!pix_q.plot || pix.plot_ready) begin
                    if (col_q != LAST_COL) begin
                        col_d = col_q + 3'd1;
                        pix_d = pixel(base_x_q, y_q + {4'd0, row_q}, bits_q, col_q + 3'd1, fg_q, bg_q);
                    end else begin
                        pix_d.plot = 1'b0;
                        if (row_q != LAST_ROW) begin
                            state_d = LOAD;
                            row_d   = row_q + 4'd1;
                        end else if (slot_q != LAST_SLOT) begin
                            // The current slot's code always sits in the low six bits.
                            state_d  = LOAD;
                            row_d    = 4'd0;
                            slot_d   = slot_q + SLOT_W'(1);
                            base_x_d = base_x_q + PITCH;
                            chars_d  = chars_q >> 4'd6;
                        end else begin
                            state_d = FINISH;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                        glyph_row_d  = row_d;
                        glyph_code_d = chars_d[5:0];
                    end
                end else begin
                    state_d = DRAW;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            slot_q       <= '0;
            row_q        <= 4'd0;
            col_q        <= 3'd0;
            base_x_q     <= 8'd0;
            y_q          <= 8'd0;
            chars_q      <= '0;
            fg_q         <= 6'd0;
            bg_q         <= 6'd0;
            bits_q       <= 8'd0;
            pix_q        <= '0;
            glyph_code_q <= 6'd0;
            glyph_row_q  <= 4'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            row_q        <= row_d;
            col_q        <= col_d;
            base_x_q     <= base_x_d;
            y_q          <= y_d;
            chars_q      <= chars_d;
            fg_q         <= fg_d;
            bg_q         <= bg_d;
            bits_q       <= bits_d;
            pix_q        <= pix_d;
            glyph_code_q <= glyph_code_d;
            glyph_row_q  <= glyph_row_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign pix.plot        = pix_q.plot;
    assign pix.plot_x      = pix_q.px;
    assign pix.plot_y      = pix_q.py;
    assign pix.plot_colour = pix_q.colour;
    assign glyph_code      = glyph_code_q;
    assign glyph_row       = glyph_row_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_text_renderer.sv
// Bench for text_renderer: an opaque 4-slot instance and a transparent 1-slot
// instance, each checked pixel-by-pixel against an expected-pixel queue.
module tb_text_renderer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_o = 1'b0, start_t = 1'b0;
    logic [7:0]  x = 8'd0, y = 8'd0;
    logic [23:0] chars_o = 24'd0;
    logic [5:0]  chars_t = 6'd0, fg = 6'd0, bg = 6'd0;
    logic [5:0]  code_o, code_t;
    logic [3:0]  row_o, row_t;
    logic [7:0]  bits_o, bits_t;
    logic        busy_o, busy_t, done_o, done_t;
    int          rom_mode = 0;
    int          checks = 0, failures = 0, cyc = 0, start_cyc = 0;
    int          done_cnt_o = 0, done_cnt_t = 0;
    logic [21:0] exp_o[$], exp_t[$], got_o[$], got_t[$];
    logic        held_o = 1'b0, held_t = 1'b0;
    logic [21:0] held_w_o = 22'd0, held_w_t = 22'd0;

    text_renderer_if pb_o ();
    text_renderer_if pb_t ();

    text_renderer #(.NUM_CHARS(4), .TRANSPARENT(1'b0)) dut_o (
        .clk(clk), .reset(reset), .start(start_o), .x(x), .y(y), .chars(chars_o),
        .fg_colour(fg), .bg_colour(bg), .glyph_code(code_o), .glyph_row(row_o),
        .glyph_bits(bits_o), .pix(pb_o), .busy(busy_o), .done(done_o));

    text_renderer #(.NUM_CHARS(1), .TRANSPARENT(1'b1)) dut_t (
        .clk(clk), .reset(reset), .start(start_t), .x(x), .y(y), .chars(chars_t),
        .fg_colour(fg), .bg_colour(bg), .glyph_code(code_t), .glyph_row(row_t),
        .glyph_bits(bits_t), .pix(pb_t), .busy(busy_t), .done(done_t));

    function automatic logic [7:0] rom_fn(input int mode, input logic [5:0] code, input logic [3:0] row);
        if (mode == 0) return 8'hFF;
        return {code, 2'b00} ^ {4'd0, row} ^ 8'hA5;
    endfunction

    function automatic logic [21:0] pw(input int px, input int py, input logic [5:0] c);
        return {8'(px), 8'(py), c};
    endfunction

    assign bits_o = rom_fn(rom_mode, code_o, row_o);
    assign bits_t = (row_t == 4'd0) ? 8'h81 : 8'h00;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected pixels: slot-major, then row, then column; opaque plots every pixel.
    task automatic gen_o(input logic [7:0] sx, input logic [7:0] sy, input logic [23:0] sc,
                         input logic [5:0] f, input logic [5:0] b);
        logic [7:0] rb;
        for (int i = 0; i < 4; i++) begin
            for (int r = 0; r < 10; r++) begin
                rb = rom_fn(rom_mode, sc[6*i +: 6], 4'(r));
                for (int c = 0; c < 8; c++)
                    exp_o.push_back(pw(int'(sx) + i*9 + c, int'(sy) + r, rb[7-c] ? f : b));
            end
        end
    endtask

    task automatic gen_t(input logic [7:0] sx, input logic [7:0] sy, input logic [5:0] f);
        logic [7:0] rb;
        for (int r = 0; r < 10; r++) begin
            rb = (r == 0) ? 8'h81 : 8'h00;
            for (int c = 0; c < 8; c++)
                if (rb[7-c]) exp_t.push_back(pw(int'(sx) + c, int'(sy) + r, f));
        end
    endtask

    task automatic start_string(input bit tdut, input logic [7:0] sx, input logic [7:0] sy,
                                input logic [23:0] sc, input logic [5:0] f, input logic [5:0] b);
        tick();
        x = sx; y = sy; fg = f; bg = b;
        if (tdut) begin
            chars_t = sc[5:0]; start_t = 1'b1; gen_t(sx, sy, f);
        end else begin
            chars_o = sc; start_o = 1'b1; gen_o(sx, sy, sc, f, b);
        end
        tick();
        start_cyc = cyc;
        start_o = 1'b0; start_t = 1'b0;
        x = ~sx; y = ~sy; fg = ~f; bg = ~b; chars_o = ~sc; chars_t = ~sc[5:0];
    endtask

    task automatic wait_done(input bit tdut, input int limit);
        int n;
        n = 0;
        while (!(tdut ? done_t : done_o) && n < limit) begin
            tick();
            n++;
        end
        check(tdut ? "done_timeout_t" : "done_timeout_o", 32'(tdut ? done_t : done_o), 32'd1);
    endtask

    // Per-cycle comparison of the opaque instance against its expected queue.
    always @(negedge clk) begin : cmp_o
        logic [21:0] w;
        w = {pb_o.plot_x, pb_o.plot_y, pb_o.plot_colour};
        if (reset) begin
            exp_o.delete();
            held_o = 1'b0;
        end else begin
            check("plot_idle_o", 32'(pb_o.plot & ~busy_o), 32'd0);
            if (held_o) check("hold_o", 32'({pb_o.plot, w}), 32'({1'b1, held_w_o}));
            if (pb_o.plot && pb_o.plot_ready) begin
                got_o.push_back(w);
                if (exp_o.size() == 0) check("extra_pix_o", 32'd1, 32'd0);
                else begin
                    check("pix_o", 32'(w), 32'(exp_o[0]));
                    void'(exp_o.pop_front());
                end
            end
            held_o = pb_o.plot && !pb_o.plot_ready;
            held_w_o = w;
            if (done_o) begin
                done_cnt_o++;
                check("drained_o", 32'(exp_o.size()), 32'd0);
            end
        end
    end

    // Per-cycle comparison of the transparent instance against its expected queue.
    always @(negedge clk) begin : cmp_t
        logic [21:0] w;
        w = {pb_t.plot_x, pb_t.plot_y, pb_t.plot_colour};
        if (reset) begin
            exp_t.delete();
            held_t = 1'b0;
        end else begin
            if (held_t) check("hold_t", 32'({pb_t.plot, w}), 32'({1'b1, held_w_t}));
            if (pb_t.plot && pb_t.plot_ready) begin
                got_t.push_back(w);
                if (exp_t.size() == 0) check("extra_pix_t", 32'd1, 32'd0);
                else begin
                    check("pix_t", 32'(w), 32'(exp_t[0]));
                    void'(exp_t.pop_front());
                end
            end
            held_t = pb_t.plot && !pb_t.plot_ready;
            held_w_t = w;
            if (done_t) begin
                done_cnt_t++;
                check("drained_t", 32'(exp_t.size()), 32'd0);
            end
        end
    end

    initial begin
        logic [21:0] w;
        int cnt0;
        pb_o.plot_ready = 1'b1;
        pb_t.plot_ready = 1'b1;
        repeat (3) tick();
        check("rst_pix_o", 32'({pb_o.plot, busy_o, done_o, pb_o.plot_x, pb_o.plot_y, pb_o.plot_colour}), 32'd0);
        check("rst_rom_o", 32'({code_o, row_o}), 32'd0);
        check("rst_pix_t", 32'({pb_t.plot, busy_t, done_t, pb_t.plot_x, pb_t.plot_y, pb_t.plot_colour}), 32'd0);
        check("rst_rom_t", 32'({code_t, row_t}), 32'd0);
        reset = 1'b0;

        // All-ones ROM, opaque, full-rate sink.
        rom_mode = 0;
        got_o.delete();
        start_string(1'b0, 8'd10, 8'd20, 24'hABCDEF, 6'h2A, 6'h15);
        wait_done(1'b0, 500);
        check("latency_o", 32'(cyc - start_cyc), 32'd360);
        start_o = 1'b1;
        tick();
        start_o = 1'b0;
        check("finish_start_ignored", 32'({busy_o, pb_o.plot}), 32'd0);
        tick();
        check("count_a", 32'(got_o.size()), 32'd320);
        check("first_a", 32'(got_o[0]), 32'(pw(10, 20, 6'h2A)));
        check("slot1_a", 32'(got_o[80]), 32'(pw(19, 20, 6'h2A)));
        check("last_a", 32'(got_o[319]), 32'(pw(44, 29, 6'h2A)));
        check("done_cnt_a", 32'(done_cnt_o), 32'd1);

        // Patterned ROM, 5-cycle stall on the 3rd pixel, then random back-pressure.
        rom_mode = 1;
        got_o.delete();
        start_string(1'b0, 8'd30, 8'd100, 24'h123456, 6'h3F, 6'h01);
        for (int n = 0; n < 50 && got_o.size() < 2; n++) tick();
        pb_o.plot_ready = 1'b0;
        repeat (5) tick();
        check("stall_px", 32'({pb_o.plot, pb_o.plot_x, pb_o.plot_y}), 32'({1'b1, 8'd32, 8'd100}));
        pb_o.plot_ready = 1'b1;
        for (int n = 0; n < 3000 && !done_o; n++) begin
            tick();
            pb_o.plot_ready = 1'($urandom_range(0, 1));
        end
        check("done_b", 32'(done_o), 32'd1);
        pb_o.plot_ready = 1'b1;
        tick();
        check("count_b", 32'(got_o.size()), 32'd320);
        check("done_cnt_b", 32'(done_cnt_o), 32'd2);

        // Horizontal wrap past column 255.
        got_o.delete();
        start_string(1'b0, 8'd250, 8'd5, 24'h0F0F0F, 6'h11, 6'h22);
        wait_done(1'b0, 500);
        tick();
        w = got_o[5]; check("wrap_255", 32'(w[21:14]), 32'd255);
        w = got_o[6]; check("wrap_0", 32'(w[21:14]), 32'd0);
        w = got_o[7]; check("wrap_1", 32'(w[21:14]), 32'd1);

        // Reset mid-draw, then a fresh string from slot 0 row 0.
        start_string(1'b0, 8'd60, 8'd60, 24'h654321, 6'h05, 6'h06);
        repeat (100) tick();
        cnt0 = done_cnt_o;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_reset", 32'({pb_o.plot, busy_o, done_o}), 32'd0);
        repeat (5) tick();
        check("no_done_after_reset", 32'(done_cnt_o - cnt0), 32'd0);
        got_o.delete();
        start_string(1'b0, 8'd70, 8'd80, 24'h13579B, 6'h07, 6'h08);
        wait_done(1'b0, 500);
        tick();
        w = got_o[0]; check("redraw_first", 32'(w[21:6]), 32'({8'd70, 8'd80}));
        check("count_d", 32'(got_o.size()), 32'd320);

        // Reset overrides a simultaneous start.
        reset = 1'b1; start_o = 1'b1;
        tick();
        reset = 1'b0; start_o = 1'b0;
        tick();
        check("reset_over_start", 32'(busy_o), 32'd0);

        // Start while busy is ignored; exactly one done.
        got_o.delete();
        cnt0 = done_cnt_o;
        start_string(1'b0, 8'd100, 8'd40, 24'h2468AC, 6'h09, 6'h0A);
        repeat (30) tick();
        x = 8'd5; start_o = 1'b1;
        tick();
        start_o = 1'b0;
        wait_done(1'b0, 500);
        repeat (3) tick();
        check("one_done", 32'(done_cnt_o - cnt0), 32'd1);
        check("count_e", 32'(got_o.size()), 32'd320);
        w = got_o[0]; check("busy_start_x", 32'(w[21:14]), 32'd100);

        // Transparent single slot: only the two set bits of row 0 are plotted.
        got_t.delete();
        start_string(1'b1, 8'd33, 8'd44, 24'h000007, 6'h2B, 6'h14);
        wait_done(1'b1, 200);
        check("latency_t", 32'(cyc - start_cyc), 32'd90);
        tick();
        check("count_t", 32'(got_t.size()), 32'd2);
        check("first_t", 32'(got_t[0]), 32'(pw(33, 44, 6'h2B)));
        check("second_t", 32'(got_t[1]), 32'(pw(40, 44, 6'h2B)));
        check("done_cnt_t", 32'(done_cnt_t), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
